// File: rtl/alu_result_hex_display.sv
// alu_result_hex_display
// Takes the 8-bit unsigned ALU result over a valid/ready handshake and
// converts it to three decimal digits with a sequential double-dabble
// engine (one shift per cycle). The digits then drive three active-low
// seven-segment displays. The displayed value holds until the next
// accepted result.
// Ports:
//   CLOCK_50      system clock, rising edge
//   RESET         synchronous active-high reset
//   result_in     ALU result, sampled on handshake only
//   result_valid  upstream valid
//   result_ready  high in IDLE (can accept)
//   busy          high while converting / updating
//   HEX0/1/2      ones / tens / hundreds, active-low segments, bit0=a..bit6=g
//   shown_value   binary value currently on the displays
module alu_result_hex_display #(
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic       result_ready,
  output logic       busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [7:0] shown_value
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  // Reset shows value 0 under the blanking rule.
  localparam logic [6:0] SEG_LEAD_RST = BLANK_LEADING_ZEROS ? SEG_BLANK : SEG_ZERO;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  state_t      state;
  logic [7:0]  bin;       // binary shift register, consumed MSB first
  logic [7:0]  captured;  // original value, kept for shown_value
  logic [11:0] bcd;
  logic [3:0]  cnt;
  logic [11:0] adj;
  logic [3:0]  hund, tens, ones;

  // Add-3 correction applied before each shift.
  always_comb begin
    adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  end

  assign hund = bcd[11:8];
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state        <= IDLE;
      bin          <= '0;
      captured     <= '0;
      bcd          <= '0;
      cnt          <= '0;
      result_ready <= 1'b1;
      busy         <= 1'b0;
      HEX0         <= SEG_ZERO;
      HEX1         <= SEG_LEAD_RST;
      HEX2         <= SEG_LEAD_RST;
      shown_value  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid) begin
            bin          <= result_in;
            captured     <= result_in;
            bcd          <= '0;
            cnt          <= '0;
            state        <= CONVERT;
            result_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd7) state <= UPDATE;
        end
        UPDATE: begin
          HEX0 <= seg7(ones);
          HEX1 <= (BLANK_LEADING_ZEROS && hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
          HEX2 <= (BLANK_LEADING_ZEROS && hund == 4'd0) ? SEG_BLANK : seg7(hund);
          shown_value  <= captured;
          state        <= IDLE;
          result_ready <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          result_ready <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_hex_display.sv
// Directed bench for alu_result_hex_display. Two instances share the
// stimulus: dut (leading-zero blanking on) and dut_nb (blanking off).
module tb_alu_result_hex_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       vld = 1'b0;
  logic       rdy, bsy, rdy_nb, bsy_nb;
  logic [6:0] h0, h1, h2, h0_nb, h1_nb, h2_nb;
  logic [7:0] sv, sv_nb;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_hex_display #(.BLANK_LEADING_ZEROS(1'b1)) dut (
    .CLOCK_50(clk), .RESET(rst), .result_in(din), .result_valid(vld),
    .result_ready(rdy), .busy(bsy), .HEX0(h0), .HEX1(h1), .HEX2(h2),
    .shown_value(sv));

  alu_result_hex_display #(.BLANK_LEADING_ZEROS(1'b0)) dut_nb (
    .CLOCK_50(clk), .RESET(rst), .result_in(din), .result_valid(vld),
    .result_ready(rdy_nb), .busy(bsy_nb), .HEX0(h0_nb), .HEX1(h1_nb), .HEX2(h2_nb),
    .shown_value(sv_nb));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present v with valid; returns #1 after the handshake edge (cycle N+1).
  task automatic send(input logic [7:0] v);
    din = v; vld = 1'b1;
    step(1);
    vld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; vld = 1'b0;
    step(2);
    rst = 1'b0;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bsy); end
    checks++; if (sv !== 8'd0) begin errors++; $display("FAIL reset_shown got=%0d exp=0", sv); end
    checks++; if (h0 !== S0) begin errors++; $display("FAIL reset_hex0 got=%b exp=%b", h0, S0); end
    checks++; if (h1 !== SB) begin errors++; $display("FAIL reset_hex1 got=%b exp=%b", h1, SB); end
    checks++; if (h2 !== SB) begin errors++; $display("FAIL reset_hex2 got=%b exp=%b", h2, SB); end
    checks++; if ({h2_nb, h1_nb, h0_nb} !== {S0, S0, S0}) begin errors++; $display("FAIL reset_nb_hex got=%b exp=%b", {h2_nb, h1_nb, h0_nb}, {S0, S0, S0}); end
  endtask

  task automatic test_max_255;
    send(8'd255);
    // Cycles N+1..N+9 busy, display unchanged.
    for (int k = 0; k < 9; k++) begin
      checks++; if (bsy !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL busy255_k%0d got=%b%b exp=10", k, bsy, rdy); end
      checks++; if (sv !== 8'd0 || h0 !== S0) begin errors++; $display("FAIL hold255_k%0d got=%0d/%b exp=0/%b", k, sv, h0, S0); end
      if (k < 8) step(1);
    end
    step(1);
    checks++; if (rdy !== 1'b1 || bsy !== 1'b0) begin errors++; $display("FAIL done255 got=%b%b exp=10", rdy, bsy); end
    checks++; if ({h2, h1, h0} !== {S2, S5, S5}) begin errors++; $display("FAIL hex255 got=%b exp=%b", {h2, h1, h0}, {S2, S5, S5}); end
    checks++; if (sv !== 8'd255) begin errors++; $display("FAIL shown255 got=%0d exp=255", sv); end
    checks++; if ({h2_nb, h1_nb, h0_nb} !== {S2, S5, S5}) begin errors++; $display("FAIL nb_hex255 got=%b exp=%b", {h2_nb, h1_nb, h0_nb}, {S2, S5, S5}); end
  endtask

  task automatic test_blank_7;
    send(8'd7);
    step(9);
    checks++; if ({h2, h1, h0} !== {SB, SB, S7}) begin errors++; $display("FAIL hex7 got=%b exp=%b", {h2, h1, h0}, {SB, SB, S7}); end
    checks++; if ({h2_nb, h1_nb, h0_nb} !== {S0, S0, S7}) begin errors++; $display("FAIL nb_hex7 got=%b exp=%b", {h2_nb, h1_nb, h0_nb}, {S0, S0, S7}); end
    checks++; if (sv !== 8'd7) begin errors++; $display("FAIL shown7 got=%0d exp=7", sv); end
  endtask

  task automatic test_interior_100;
    send(8'd100);
    step(9);
    checks++; if ({h2, h1, h0} !== {S1, S0, S0}) begin errors++; $display("FAIL hex100 got=%b exp=%b", {h2, h1, h0}, {S1, S0, S0}); end
    checks++; if (sv !== 8'd100) begin errors++; $display("FAIL shown100 got=%0d exp=100", sv); end
  endtask

  task automatic test_back_to_back;
    din = 8'd3; vld = 1'b1;
    step(1);              // handshake of 3 at edge ending N; now cycle N+1
    step(2);              // cycle N+3
    din = 8'd42;          // valid stays high, ignored while busy
    step(7);              // cycle N+10
    checks++; if ({h2, h1, h0} !== {SB, SB, S3}) begin errors++; $display("FAIL b2b_hex3 got=%b exp=%b", {h2, h1, h0}, {SB, SB, S3}); end
    checks++; if (sv !== 8'd3 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_shown3 got=%0d/%b exp=3/1", sv, rdy); end
    step(1);              // 42 accepted at edge ending N+10
    vld = 1'b0;
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL b2b_busy42 got=%b exp=1", bsy); end
    step(9);              // cycle N+20
    checks++; if ({h2, h1, h0} !== {SB, S4, S2}) begin errors++; $display("FAIL b2b_hex42 got=%b exp=%b", {h2, h1, h0}, {SB, S4, S2}); end
    checks++; if (sv !== 8'd42) begin errors++; $display("FAIL b2b_shown42 got=%0d exp=42", sv); end
  endtask

  task automatic test_reset_mid;
    send(8'd200);         // cycle N+1
    step(3);              // cycle N+4
    step(1);              // cycle N+5
    rst = 1'b1;
    step(1);              // reset edge ends N+5; cycle N+6
    rst = 1'b0;
    checks++; if (rdy !== 1'b1 || bsy !== 1'b0) begin errors++; $display("FAIL midrst_hs got=%b%b exp=10", rdy, bsy); end
    checks++; if ({h2, h1, h0, sv} !== {SB, SB, S0, 8'd0}) begin errors++; $display("FAIL midrst_disp got=%b exp=%b", {h2, h1, h0, sv}, {SB, SB, S0, 8'd0}); end
    step(12);             // aborted conversion must not surface later
    checks++; if (sv !== 8'd0) begin errors++; $display("FAIL midrst_noupd got=%0d exp=0", sv); end
    send(8'd9);
    step(9);
    checks++; if ({h2, h1, h0, sv} !== {SB, SB, S9, 8'd9}) begin errors++; $display("FAIL after_rst9 got=%b exp=%b", {h2, h1, h0, sv}, {SB, SB, S9, 8'd9}); end
    checks++; if ({h2_nb, h1_nb, h0_nb} !== {S0, S0, S9}) begin errors++; $display("FAIL nb_after_rst9 got=%b exp=%b", {h2_nb, h1_nb, h0_nb}, {S0, S0, S9}); end
  endtask

  task automatic test_reset_wins;
    din = 8'd77; vld = 1'b1; rst = 1'b1;
    step(1);
    vld = 1'b0; rst = 1'b0;
    checks++; if (bsy !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL rstwin_hs got=%b%b exp=01", bsy, rdy); end
    step(10);
    checks++; if (sv !== 8'd0) begin errors++; $display("FAIL rstwin_shown got=%0d exp=0", sv); end
  endtask

  task automatic test_zero_noblank;
    send(8'd255);         // make the display non-zero first
    step(9);
    send(8'd0);
    step(9);
    checks++; if ({h2_nb, h1_nb, h0_nb} !== {S0, S0, S0}) begin errors++; $display("FAIL nb_hex0 got=%b exp=%b", {h2_nb, h1_nb, h0_nb}, {S0, S0, S0}); end
    checks++; if (sv_nb !== 8'd0 || rdy_nb !== 1'b1) begin errors++; $display("FAIL nb_shown0 got=%0d/%b exp=0/1", sv_nb, rdy_nb); end
    checks++; if ({h2, h1, h0} !== {SB, SB, S0}) begin errors++; $display("FAIL hex0 got=%b exp=%b", {h2, h1, h0}, {SB, SB, S0}); end
  endtask

  initial begin
    test_reset;
    test_max_255;
    test_blank_7;
    test_interior_100;
    test_back_to_back;
    test_reset_mid;
    test_reset_wins;
    test_zero_noblank;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
